// File: rtl/alu_operand_stage_if.sv
// Signal bundle between decode/ALU and the operand stage.
// The stage itself uses the slave modport; the driving side uses master.
interface alu_operand_stage_if;
   logic        IN_VALID;
   logic        STALL;
   logic        FLUSH;
   logic [1:0]  ALU_OP;
   logic [5:0]  FUNCT;
   logic [4:0]  RS_ADDR;
   logic [4:0]  RT_ADDR;
   logic [4:0]  RD_ADDR;
   logic        REG_WRITE;
   logic        ALU_SRC;
   logic [31:0] RS_DATA;
   logic [31:0] RT_DATA;
   logic [15:0] IMM16;
   logic [31:0] FWD_RES;
   logic [31:0] INOP1;
   logic [31:0] INOP2;
   logic [2:0]  S_OP;
   logic        OUT_VALID;
   logic [4:0]  OUT_RD;
   logic        OUT_REGWRITE;
   logic        ILL_FN;

   modport master (
      output IN_VALID, STALL, FLUSH, ALU_OP, FUNCT,
             RS_ADDR, RT_ADDR, RD_ADDR, REG_WRITE, ALU_SRC,
             RS_DATA, RT_DATA, IMM16, FWD_RES,
      input  INOP1, INOP2, S_OP, OUT_VALID, OUT_RD, OUT_REGWRITE, ILL_FN
   );

   modport slave (
      input  IN_VALID, STALL, FLUSH, ALU_OP, FUNCT,
             RS_ADDR, RT_ADDR, RD_ADDR, REG_WRITE, ALU_SRC,
             RS_DATA, RT_DATA, IMM16, FWD_RES,
      output INOP1, INOP2, S_OP, OUT_VALID, OUT_RD, OUT_REGWRITE, ILL_FN
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-select pipeline register in front of the ALU.
// Decodes the ALU operation, extends the immediate and bypasses the ALU's
// own result (FWD_RES) into the next instruction's operands.
module alu_operand_stage (
   input logic                CLK,
   input logic                RST,
   alu_operand_stage_if.slave bus
);

   localparam logic [2:0] SOP_ADD = 3'b010;
   localparam logic [2:0] SOP_SUB = 3'b110;
   localparam logic [2:0] SOP_AND = 3'b000;
   localparam logic [2:0] SOP_OR  = 3'b001;
   localparam logic [2:0] SOP_SLT = 3'b111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [31:0] inop1_q, inop1_d;
   logic [31:0] inop2_q, inop2_d;
   logic [2:0]  s_op_q, s_op_d;
   logic        out_valid_q, out_valid_d;
   logic [4:0]  out_rd_q, out_rd_d;
   logic        out_regwrite_q, out_regwrite_d;
   logic        ill_fn_q, ill_fn_d;

   logic [2:0]  s_op_dec;
   logic        ill_fn_dec;
   logic        held_writes;
   logic        fwd_rs;
   logic        fwd_rt;
   logic [31:0] imm_ext;
   logic [31:0] op1_sel;
   logic [31:0] op2_sel;

   // ALU operation decode from op class and function field
   always_comb begin
      s_op_dec   = SOP_AND;
      ill_fn_dec = 1'b0;
      case (bus.ALU_OP)
         2'b00:   s_op_dec = SOP_ADD;
         2'b01:   s_op_dec = SOP_SUB;
         2'b11:   s_op_dec = SOP_OR;
         default: begin
            case (bus.FUNCT)
               FN_ADD:  s_op_dec = SOP_ADD;
               FN_SUB:  s_op_dec = SOP_SUB;
               FN_AND:  s_op_dec = SOP_AND;
               FN_OR:   s_op_dec = SOP_OR;
               FN_SLT:  s_op_dec = SOP_SLT;
               default: begin
                  s_op_dec   = SOP_AND;
                  ill_fn_dec = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Bypass match against the currently held instruction; r0 never forwards
   always_comb begin
      held_writes = out_valid_q && out_regwrite_q && (out_rd_q != 5'd0);
      fwd_rs      = held_writes && (out_rd_q == bus.RS_ADDR);
      fwd_rt      = held_writes && (out_rd_q == bus.RT_ADDR);
   end

   // Immediate extension: ori zero-extends, everything else sign-extends
   always_comb begin
      if (bus.ALU_OP == 2'b11) begin
         imm_ext = {16'h0000, bus.IMM16};
      end else begin
         imm_ext = {{16{bus.IMM16[15]}}, bus.IMM16};
      end
   end

   // Operand selection; the immediate path is never bypassed
   always_comb begin
      op1_sel = fwd_rs ? bus.FWD_RES : bus.RS_DATA;
      if (bus.ALU_SRC) begin
         op2_sel = imm_ext;
      end else begin
         op2_sel = fwd_rt ? bus.FWD_RES : bus.RT_DATA;
      end
   end

   // Next-state: flush beats stall, stall holds, otherwise load or bubble
   always_comb begin
      inop1_d        = inop1_q;
      inop2_d        = inop2_q;
      s_op_d         = s_op_q;
      out_valid_d    = out_valid_q;
      out_rd_d       = out_rd_q;
      out_regwrite_d = out_regwrite_q;
      ill_fn_d       = ill_fn_q;
      if (bus.FLUSH || (!bus.STALL && !bus.IN_VALID)) begin
         inop1_d        = 32'd0;
         inop2_d        = 32'd0;
         s_op_d         = SOP_AND;
         out_valid_d    = 1'b0;
         out_rd_d       = 5'd0;
         out_regwrite_d = 1'b0;
         ill_fn_d       = 1'b0;
      end else if (!bus.STALL) begin
         inop1_d        = op1_sel;
         inop2_d        = op2_sel;
         s_op_d         = s_op_dec;
         out_valid_d    = 1'b1;
         out_rd_d       = bus.RD_ADDR;
         out_regwrite_d = bus.REG_WRITE;
         ill_fn_d       = ill_fn_dec;
      end
   end

   // Pipeline register with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         inop1_q        <= 32'd0;
         inop2_q        <= 32'd0;
         s_op_q         <= SOP_AND;
         out_valid_q    <= 1'b0;
         out_rd_q       <= 5'd0;
         out_regwrite_q <= 1'b0;
         ill_fn_q       <= 1'b0;
      end else begin
         inop1_q        <= inop1_d;
         inop2_q        <= inop2_d;
         s_op_q         <= s_op_d;
         out_valid_q    <= out_valid_d;
         out_rd_q       <= out_rd_d;
         out_regwrite_q <= out_regwrite_d;
         ill_fn_q       <= ill_fn_d;
      end
   end

   // Registered outputs straight from the flops
   always_comb begin
      bus.INOP1        = inop1_q;
      bus.INOP2        = inop2_q;
      bus.S_OP         = s_op_q;
      bus.OUT_VALID    = out_valid_q;
      bus.OUT_RD       = out_rd_q;
      bus.OUT_REGWRITE = out_regwrite_q;
      bus.ILL_FN       = ill_fn_q;
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   alu_operand_stage_if bus ();

   alu_operand_stage dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.OUT_VALID}, 32'd0);
      chk({tag, "_regwr"}, {31'd0, bus.OUT_REGWRITE}, 32'd0);
      chk({tag, "_rd"}, {27'd0, bus.OUT_RD}, 32'd0);
      chk({tag, "_op1"}, bus.INOP1, 32'd0);
      chk({tag, "_op2"}, bus.INOP2, 32'd0);
      chk({tag, "_sop"}, {29'd0, bus.S_OP}, 32'd0);
      chk({tag, "_ill"}, {31'd0, bus.ILL_FN}, 32'd0);
   endtask

   logic [5:0] fn_tab  [6];
   logic [2:0] sop_tab [6];
   logic       ill_tab [6];

   initial begin
      fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      sop_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b000};
      ill_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // reset with IN_VALID and STALL asserted, nonzero inputs
      RST = 1'b1;
      bus.IN_VALID = 1'b1;  bus.STALL = 1'b1;  bus.FLUSH = 1'b0;
      bus.ALU_OP = 2'b00;   bus.FUNCT = 6'd0;
      bus.RS_ADDR = 5'd1;   bus.RT_ADDR = 5'd2;  bus.RD_ADDR = 5'd7;
      bus.REG_WRITE = 1'b1; bus.ALU_SRC = 1'b0;
      bus.RS_DATA = 32'hDEAD_BEEF; bus.RT_DATA = 32'h1234_5678;
      bus.IMM16 = 16'hFFFF; bus.FWD_RES = 32'hAAAA_5555;
      step();
      chk_bubble("rst1");
      step();
      chk_bubble("rst2");

      // decode sweep over R-type functions
      RST = 1'b0; bus.STALL = 1'b0; bus.REG_WRITE = 1'b0;
      bus.ALU_OP = 2'b10;
      for (int i = 0; i < 6; i++) begin
         bus.FUNCT = fn_tab[i];
         step();
         chk($sformatf("dec_sop_%0d", i), {29'd0, bus.S_OP}, {29'd0, sop_tab[i]});
         chk($sformatf("dec_ill_%0d", i), {31'd0, bus.ILL_FN}, {31'd0, ill_tab[i]});
         chk($sformatf("dec_vld_%0d", i), {31'd0, bus.OUT_VALID}, 32'd1);
      end
      chk("dec_op1", bus.INOP1, 32'hDEAD_BEEF);
      chk("dec_op2", bus.INOP2, 32'h1234_5678);
      bus.ALU_OP = 2'b01; bus.FUNCT = 6'b000000;
      step();
      chk("sub_sop", {29'd0, bus.S_OP}, 32'd6);
      chk("sub_ill", {31'd0, bus.ILL_FN}, 32'd0);

      // immediate extension
      bus.ALU_SRC = 1'b1; bus.IMM16 = 16'h8001; bus.ALU_OP = 2'b00;
      step();
      chk("imm_sext", bus.INOP2, 32'hFFFF_8001);
      chk("imm_add_sop", {29'd0, bus.S_OP}, 32'd2);
      bus.ALU_OP = 2'b11;
      step();
      chk("imm_zext", bus.INOP2, 32'h0000_8001);
      chk("imm_or_sop", {29'd0, bus.S_OP}, 32'd1);

      // producer RD=5
      bus.ALU_SRC = 1'b0; bus.ALU_OP = 2'b00;
      bus.RD_ADDR = 5'd5; bus.REG_WRITE = 1'b1;
      step();
      chk("prod_rd", {27'd0, bus.OUT_RD}, 32'd5);
      chk("prod_rw", {31'd0, bus.OUT_REGWRITE}, 32'd1);
      // dependent on r5, itself writes r0
      bus.FWD_RES = 32'd77;
      bus.RS_ADDR = 5'd5; bus.RT_ADDR = 5'd5;
      bus.RS_DATA = 32'd1; bus.RT_DATA = 32'd1;
      bus.RD_ADDR = 5'd0;
      step();
      chk("fwd_op1", bus.INOP1, 32'd77);
      chk("fwd_op2", bus.INOP2, 32'd77);
      // reader of r0 must not forward; this one writes r3
      bus.RS_ADDR = 5'd0; bus.RT_ADDR = 5'd0;
      bus.RD_ADDR = 5'd3;
      step();
      chk("r0_op1", bus.INOP1, 32'd1);
      chk("r0_op2", bus.INOP2, 32'd1);
      chk("r0_rd", {27'd0, bus.OUT_RD}, 32'd3);

      // stall three cycles with changing inputs
      bus.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.IN_VALID = i[0];
         bus.RD_ADDR = 5'(9 + i); bus.RS_DATA = 32'(100 + i);
         bus.RT_DATA = 32'(200 + i); bus.ALU_OP = 2'b10;
         bus.FUNCT = 6'b000000;
         step();
         chk($sformatf("stall_op1_%0d", i), bus.INOP1, 32'd1);
         chk($sformatf("stall_op2_%0d", i), bus.INOP2, 32'd1);
         chk($sformatf("stall_rd_%0d", i), {27'd0, bus.OUT_RD}, 32'd3);
         chk($sformatf("stall_vld_%0d", i), {31'd0, bus.OUT_VALID}, 32'd1);
         chk($sformatf("stall_sop_%0d", i), {29'd0, bus.S_OP}, 32'd2);
         chk($sformatf("stall_ill_%0d", i), {31'd0, bus.ILL_FN}, 32'd0);
      end

      // after release, dependent on r3 forwards; it also writes r3
      bus.STALL = 1'b0; bus.IN_VALID = 1'b1; bus.ALU_OP = 2'b00;
      bus.RS_ADDR = 5'd3; bus.RT_ADDR = 5'd8; bus.RS_DATA = 32'd9;
      bus.RT_DATA = 32'd4; bus.RD_ADDR = 5'd3; bus.FWD_RES = 32'd55;
      step();
      chk("post_stall_op1", bus.INOP1, 32'd55);
      chk("post_stall_op2", bus.INOP2, 32'd4);

      // flush with stall: flush wins
      bus.STALL = 1'b1; bus.FLUSH = 1'b1;
      step();
      chk_bubble("flush");

      // no forwarding after flush even though FWD_RES is stale
      bus.STALL = 1'b0; bus.FLUSH = 1'b0;
      bus.FWD_RES = 32'd123; bus.RD_ADDR = 5'd4;
      step();
      chk("post_flush_op1", bus.INOP1, 32'd9);
      chk("post_flush_vld", {31'd0, bus.OUT_VALID}, 32'd1);

      // immediate operand never forwarded; RS still forwards from r4
      bus.ALU_SRC = 1'b1; bus.RS_ADDR = 5'd4; bus.RT_ADDR = 5'd4;
      bus.IMM16 = 16'h0010; bus.FWD_RES = 32'd200;
      step();
      chk("immfwd_op1", bus.INOP1, 32'd200);
      chk("immfwd_op2", bus.INOP2, 32'h0000_0010);

      // bubble
      bus.IN_VALID = 1'b0;
      step();
      chk_bubble("bubble");

      // reset wins over stall mid-operation
      bus.IN_VALID = 1'b1; bus.ALU_SRC = 1'b0;
      step();
      chk("pre_rst_vld", {31'd0, bus.OUT_VALID}, 32'd1);
      RST = 1'b1; bus.STALL = 1'b1;
      step();
      chk_bubble("rst_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
